// File: rtl/backup_mem_ctrl.sv
// Backup-memory controller, host side. Sits behind the memory-backup
// deserializer's wide port: accepts tagged line read/write commands, moves
// BEATS data beats per line, and keeps lines in a flat word array "ram".
// The array is not reset so a harness can preload it by hierarchical name.
module backup_mem_ctrl #(
    parameter int ADDR_BITS    = 26,
    parameter int TAG_BITS     = 5,
    parameter int DATA_BITS    = 128,
    parameter int BEATS        = 4,
    parameter int DEPTH_LOG2   = 20,
    parameter int READ_LATENCY = 2
) (
    input  logic                 htif_clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic                 mem_req_rw,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_req_data_valid,
    output logic                 mem_req_data_ready,
    input  logic [DATA_BITS-1:0] mem_req_data_bits,
    output logic                 mem_resp_valid,
    output logic [DATA_BITS-1:0] mem_resp_data,
    output logic [TAG_BITS-1:0]  mem_resp_tag
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam int LINE_W = DEPTH_LOG2 - BEAT_W;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_READ_WAIT = 2'd2;
    localparam logic [1:0] S_READ      = 2'd3;

    logic [DATA_BITS-1:0] ram [0:(1<<DEPTH_LOG2)-1];

    logic [1:0]           state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [LINE_W-1:0]    addr_q, addr_d;
    logic [TAG_BITS-1:0]  tag_q, tag_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [DATA_BITS-1:0] resp_data_q, resp_data_d;
    logic [TAG_BITS-1:0]  resp_tag_q, resp_tag_d;

    logic                 ram_we;
    logic [BEAT_W-1:0]    rd_beat;
    logic [DATA_BITS-1:0] rd_word;

    // Only the low line bits index the array; higher address bits alias.
    generate
        if (ADDR_BITS > LINE_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:LINE_W];
        end
    endgenerate

    // Beat that will be presented next cycle: the first beat when leaving
    // READ_WAIT, otherwise the one after the beat currently on the bus.
    assign rd_beat = (state_q == S_READ) ? beat_q + 1'b1 : '0;
    assign rd_word = ram[{addr_q, rd_beat}];
    assign ram_we  = (state_q == S_WRITE) && mem_req_data_valid && !reset;

    // Everything visible is forced low while reset is held.
    assign mem_req_ready      = (state_q == S_IDLE) && !reset;
    assign mem_req_data_ready = (state_q == S_WRITE) && !reset;
    assign mem_resp_valid     = resp_valid_q && !reset;
    assign mem_resp_data      = reset ? '0 : resp_data_q;
    assign mem_resp_tag       = reset ? '0 : resp_tag_q;

    // Next-state / datapath: command accept, beat sequencing, read latency.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req_valid) begin
                    addr_d = mem_req_addr[LINE_W-1:0];
                    beat_d = '0;
                    if (mem_req_rw) begin
                        state_d = S_WRITE;
                    end else begin
                        tag_d   = mem_req_tag;
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                        state_d = S_READ_WAIT;
                    end
                end
            end
            S_WRITE: begin
                if (mem_req_data_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = S_IDLE;
                end
            end
            S_READ_WAIT: begin
                if (lat_q == '0) begin
                    state_d      = S_READ;
                    beat_d       = '0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = rd_word;
                    resp_tag_d   = tag_q;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_READ: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_IDLE;
                end else begin
                    beat_d       = beat_q + 1'b1;
                    resp_valid_d = 1'b1;
                    resp_data_d  = rd_word;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; synchronous reset aborts any transaction.
    always_ff @(posedge htif_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            lat_q        <= '0;
            addr_q       <= '0;
            tag_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            lat_q        <= lat_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    // Line storage write port; contents survive reset.
    always_ff @(posedge htif_clk) begin
        if (ram_we) ram[{addr_q, beat_q}] <= mem_req_data_bits;
    end

endmodule

// File: tb/tb_backup_mem_ctrl.sv
// Directed bench for backup_mem_ctrl with a 16-word array (4 lines of 4 beats)
// so that line addresses alias. Inputs change 1 time unit after posedge,
// outputs are checked 2 units after posedge.
module tb_backup_mem_ctrl;

    localparam int AW = 26;
    localparam int TW = 5;
    localparam int DW = 128;

    logic          htif_clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic [TW-1:0] mem_resp_tag;

    int checks = 0;
    int errors = 0;

    backup_mem_ctrl #(
        .ADDR_BITS(AW), .TAG_BITS(TW), .DATA_BITS(DW),
        .BEATS(4), .DEPTH_LOG2(4), .READ_LATENCY(2)
    ) dut (
        .htif_clk(htif_clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
    );

    always #5 htif_clk = ~htif_clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge htif_clk);
        #1;
    endtask

    // Write one line; gap idle cycles precede every beat.
    task automatic write_line(input logic [AW-1:0] a, input logic [3:0][DW-1:0] d, input int gap);
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = a; mem_req_tag = 5'd3;
        #1;
        chk("wr_req_ready", 128'(mem_req_ready), 128'd1);
        chk("wr_data_ready_idle", 128'(mem_req_data_ready), 128'd0);
        step();
        mem_req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_req_data_valid = 1'b0;
                #1;
                chk("wr_stall_req_ready", 128'(mem_req_ready), 128'd0);
                step();
            end
            mem_req_data_valid = 1'b1; mem_req_data_bits = d[b];
            #1;
            chk("wr_data_ready", 128'(mem_req_data_ready), 128'd1);
            chk("wr_busy_req_ready", 128'(mem_req_ready), 128'd0);
            step();
        end
        mem_req_data_valid = 1'b0;
        #1;
        chk("wr_done_req_ready", 128'(mem_req_ready), 128'd1);
    endtask

    // Read one line and check the exact beat timing; if abort_at < 4, reset
    // is pulsed in the cycle where that beat would appear.
    task automatic read_line(input logic [AW-1:0] a, input logic [TW-1:0] t,
                             input logic [3:0][DW-1:0] d, input int abort_at);
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = a; mem_req_tag = t;
        #1;
        chk("rd_req_ready", 128'(mem_req_ready), 128'd1);
        step();
        mem_req_valid = 1'b0; mem_req_tag = '0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            chk("rd_wait_valid", 128'(mem_resp_valid), 128'd0);
            chk("rd_wait_req_ready", 128'(mem_req_ready), 128'd0);
            step();
        end
        for (int b = 0; b < 4; b++) begin
            if (b == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_resp_valid", 128'(mem_resp_valid), 128'd0);
                step();
                reset = 1'b0;
                #1;
                chk("post_rst_resp_valid", 128'(mem_resp_valid), 128'd0);
                chk("post_rst_req_ready", 128'(mem_req_ready), 128'd1);
                return;
            end
            #1;
            chk("rd_valid", 128'(mem_resp_valid), 128'd1);
            chk("rd_data", mem_resp_data, d[b]);
            chk("rd_tag", 128'(mem_resp_tag), 128'(t));
            chk("rd_beat_req_ready", 128'(mem_req_ready), 128'd0);
            step();
        end
        #1;
        chk("rd_done_valid", 128'(mem_resp_valid), 128'd0);
        chk("rd_done_req_ready", 128'(mem_req_ready), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0][DW-1:0] la, lb, lc, l0, l1;
        la = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
        lb = {128'hB3, 128'hB2, 128'hB1, 128'hB0};
        lc = {128'hC3, 128'hC2, 128'hC1, 128'hC0};
        l0 = {128'h0000_0003_0000_0000_0000_0000_0000_0000, 128'h0000_0000_0000_0002_0000_0000_0000_0000,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        l1 = {128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA,
              128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D, 128'h1111_2222_3333_4444_5555_6666_7777_8888};

        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_tag = '0;
        mem_req_data_valid = 1'b0; mem_req_data_bits = '0;

        // Reset held 3 cycles with a pending command
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("rst_req_ready", 128'(mem_req_ready), 128'd0);
            chk("rst_data_ready", 128'(mem_req_data_ready), 128'd0);
            chk("rst_resp_valid", 128'(mem_resp_valid), 128'd0);
        end
        step();
        reset = 1'b0; mem_req_valid = 1'b0;
        #1;
        chk("release_req_ready", 128'(mem_req_ready), 128'd1);
        chk("release_resp_data", mem_resp_data, 128'd0);
        chk("release_resp_tag", 128'(mem_resp_tag), 128'd0);

        // Basic write / read-back
        write_line(26'h12, la, 0);
        read_line(26'h12, 5'd7, la, 4);

        // Write with 2-cycle gaps before each beat
        write_line(26'h12, lb, 2);
        read_line(26'h12, 5'd9, lb, 4);

        // Line 5 aliases line 1 in a 4-line array
        write_line(26'h1, lc, 0);
        read_line(26'h5, 5'd1, lc, 4);

        // Reset in the cycle after the 2nd response beat, then a clean re-read
        read_line(26'h12, 5'd7, lb, 2);
        read_line(26'h12, 5'd7, lb, 4);

        // Wide patterns in lines 0 and 1, then back-to-back reads
        write_line(26'h0, l0, 0);
        write_line(26'h1, l1, 1);
        read_line(26'h0, 5'd2, l0, 4);
        read_line(26'h1, 5'd31, l1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/backup_mem_ctrl.md
Name: backup_mem_ctrl

Overview:
- Behavioural backup-memory controller on the host side; directly downstream of the memory-backup deserializer's wide request/response port.
- Accepts tagged line read/write commands, collects or emits BEATS data beats per line, and stores lines in an internal word array.
- Provides the memory-backup path when the backup enable is set. Simulation-only; not synthesized.

Parameters:
- ADDR_BITS, 26, line address width of cmd addr.
- TAG_BITS, 5, transaction tag width.
- DATA_BITS, 128, beat width.
- BEATS, 4, beats per line; power of two, >=2.
- DEPTH_LOG2, 20, log2 of array depth in beats; must be > log2(BEATS).
- READ_LATENCY, 2, idle cycles between read accept and first response beat; >=1.

Ports:
- htif_clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_req_valid  in  1  command valid
- mem_req_ready  out  1  command ready
- mem_req_rw  in  1  1=write, 0=read
- mem_req_addr  in  ADDR_BITS  line address
- mem_req_tag  in  TAG_BITS  transaction tag
- mem_req_data_valid  in  1  write beat valid
- mem_req_data_ready  out  1  write beat ready
- mem_req_data_bits  in  DATA_BITS  write beat
- mem_resp_valid  out  1  read beat valid; no ready, consumer must sink every beat
- mem_resp_data  out  DATA_BITS  read beat
- mem_resp_tag  out  TAG_BITS  tag of the read being returned

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is htif_clk. All state changes on posedge htif_clk.
- Storage: array "ram", 2**DEPTH_LOG2 words of DATA_BITS each. Hierarchical name is fixed so the harness can $readmemh into it. Not cleared by reset.
- Beat index = {addr[DEPTH_LOG2-log2(BEATS)-1:0], beat}. Upper addr bits are ignored, so addresses alias modulo the array size.
- States: IDLE, WRITE, READ_WAIT, READ. Reset forces IDLE and clears the beat counter, latency counter, latched addr and tag.
- Outputs during reset and their reset values: req_ready=0, data_ready=0, resp_valid=0, resp_data=0, resp_tag=0.
- req_ready = (state==IDLE) && !reset. Handshake on valid&&ready.
- data_ready = (state==WRITE). Beats are never accepted in IDLE, including in the same cycle as the write cmd.
- IDLE, write handshake -> WRITE. Latch addr; beat counter=0.
- WRITE: each data handshake writes ram[index] and increments the beat counter. Gaps in data_valid are allowed and simply stall.
- WRITE -> IDLE on the handshake of beat BEATS-1. req_ready is high in the next cycle. No write response is generated.
- IDLE, read handshake -> READ_WAIT. Latch addr and tag; latency counter=READ_LATENCY-1.
- READ_WAIT: decrement the counter each cycle; at 0 -> READ with beat=0.
- READ: resp_valid=1 every cycle for BEATS consecutive cycles. resp_data=ram[index of current beat]; resp_tag=latched tag. Beat increments each cycle; after beat BEATS-1 -> IDLE.
- Read timing: with read cmd accepted on edge 0, beats appear in cycles READ_LATENCY+1 .. READ_LATENCY+BEATS. req_ready returns in cycle READ_LATENCY+BEATS+1.
- resp_data/resp_tag are registered and hold their last value when resp_valid=0.
- Read-after-write to the same line returns the new data, since the write completes before the read is accepted.
- Only one outstanding transaction. Back-to-back commands are separated by at least one IDLE cycle.
- Reset mid-transaction: abort immediately. Beats already written stay in ram; the remaining beats are dropped; no further resp beats. IDLE in the first cycle after reset deasserts.
- Beat counter width is log2(BEATS); wrap at BEATS-1 is the terminal condition, never a silent overflow.

Test Plan:
- Reset: hold reset 3 cycles with req_valid=1 -> req_ready, data_ready and resp_valid all 0 throughout; req_ready=1 in the first cycle after release.
- Write/read-back: write addr 0x12, tag 3, beats 0xA0..0xA3, then read addr 0x12 tag 7 -> 4 resp beats 0xA0..0xA3, each with tag 7, in cycles 3..6 after accept (READ_LATENCY=2); req_ready high in cycle 7.
- Stalled write: same write with data_valid low for 2 cycles between each beat -> all 4 beats stored; read-back matches; req_ready stays low until the beat-3 handshake.
- Alias: with DEPTH_LOG2=4 and BEATS=4, write line 1, then read line 5 -> the data written to line 1 is returned.
- Reset mid-read: assert reset the cycle after the 2nd resp beat -> resp_valid=0 from the next cycle; a subsequent read of the same line still returns the full original data.
- Preload: $readmemh pattern into ram, then read lines 0 and 1 back-to-back -> data matches the file; exactly one IDLE cycle with req_ready=1 between the two read transactions.
